spn_req_scheduler: RTL and testbench

- Shares one spn_cu_top encryption/decryption core between two independent requesters (ports 0 and 1).
- Per request: round-robin arbitration, valid/ready capture, a one-cycle opcode issue to the core, checking of the core's valid code, and a registered response held until the requester accepts it.
- Sits between the host-side request logic and the spn_if bus of the core.

---
 rtl/spn_sched_pkg.sv | 25 ++
 rtl/spn_rr_arb2.sv | 18 +
 rtl/spn_req_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_spn_req_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spn_sched_pkg.sv
// Shared types and constants for the SPN request scheduler.
package spn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ILLEGAL  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_MISMATCH = 2'b11;

  // Only encrypt and decrypt are understood by the core.
  function automatic logic isLegalOp(input logic [1:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/spn_rr_arb2.sv
// Two-way round-robin grant; the pointer register is held by the caller.
module spn_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // When both request, the pointer picks the winner; otherwise the lone requester wins.
  always_comb begin
    o_grant = 2'b00;
    if (&i_req) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_req;
    end
  end

endmodule

// File: rtl/spn_req_scheduler.sv
// Shares one SPN encrypt/decrypt core between two requesters with
// round-robin arbitration and held, registered responses.
module spn_req_scheduler
  import spn_sched_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_data,
  input  logic [63:0] req_key,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [1:0]  core_opcode,
  output logic [15:0] core_data_in,
  output logic [31:0] core_key,
  input  logic [1:0]  core_valid,
  input  logic [15:0] core_data_out
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  sched_state_t r_state;
  sched_state_t w_nextState;

  logic        r_ptr;
  logic        r_id;
  logic [1:0]  r_op;
  logic [15:0] r_coreData;
  logic [31:0] r_coreKey;
  logic [3:0]  r_waitCnt;
  logic [1:0]  r_rspValid;
  logic [15:0] r_rspData;
  logic [1:0]  r_rspStatus;
  logic [7:0]  r_errCount;

  logic [1:0]  w_grant;
  logic [1:0]  w_reqReady;
  logic        w_busy;
  logic [1:0]  w_coreOpcode;
  logic        w_handshake;
  logic        w_winId;
  logic [1:0]  w_winOp;
  logic [15:0] w_winData;
  logic [31:0] w_winKey;
  logic        w_enterResp;
  logic        w_rspId;
  logic [1:0]  w_rspStatus;
  logic [15:0] w_rspData;
  logic        w_rspDone;

  spn_rr_arb2 u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_handshake = |(req_valid & w_reqReady);
  assign w_winId     = w_grant[1];
  assign w_winOp     = w_winId ? req_op[3:2]    : req_op[1:0];
  assign w_winData   = w_winId ? req_data[31:16] : req_data[15:0];
  assign w_winKey    = w_winId ? req_key[63:32]  : req_key[31:0];
  assign w_rspDone   = (r_state == RESP) && rsp_ready[r_id];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the response that would be latched on entry to RESP.
  always_comb begin
    w_nextState = r_state;
    w_enterResp = 1'b0;
    w_rspId     = r_id;
    w_rspStatus = ST_OK;
    w_rspData   = 16'h0000;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          if (isLegalOp(w_winOp)) begin
            w_nextState = ISSUE;
          end else begin
            w_nextState = RESP;
            w_enterResp = 1'b1;
            w_rspId     = w_winId;
            w_rspStatus = ST_ILLEGAL;
          end
        end
      end
      ISSUE: begin
        w_nextState = WAIT;
      end
      WAIT: begin
        if (core_valid == r_op) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
          w_rspStatus = ST_OK;
          w_rspData   = core_data_out;
        end else if (core_valid != OP_NOP) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
          w_rspStatus = ST_MISMATCH;
        end else if (r_waitCnt == TIMEOUT_CNT) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
          w_rspStatus = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (rsp_ready[r_id]) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State-decoded outputs: ready only in IDLE, opcode pulse only in ISSUE.
  always_comb begin
    w_reqReady   = 2'b00;
    w_busy       = 1'b1;
    w_coreOpcode = OP_NOP;
    case (r_state)
      IDLE: begin
        w_reqReady = w_grant;
        w_busy     = 1'b0;
      end
      ISSUE: begin
        w_coreOpcode = r_op;
      end
      default: begin
        w_coreOpcode = OP_NOP;
      end
    endcase
  end

  // Request capture, wait counter, response registers, error count and pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_op        <= OP_NOP;
      r_coreData  <= 16'h0000;
      r_coreKey   <= 32'h0000_0000;
      r_waitCnt   <= 4'd0;
      r_rspValid  <= 2'b00;
      r_rspData   <= 16'h0000;
      r_rspStatus <= ST_OK;
      r_errCount  <= 8'h00;
    end else begin
      if (w_handshake) begin
        r_id <= w_winId;
        r_op <= w_winOp;
        if (isLegalOp(w_winOp)) begin
          r_coreData <= w_winData;
          r_coreKey  <= w_winKey;
        end
      end
      if (r_state == ISSUE) begin
        r_waitCnt <= 4'd1;
      end else if (r_state == WAIT) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_enterResp) begin
        r_rspValid  <= w_rspId ? 2'b10 : 2'b01;
        r_rspData   <= w_rspData;
        r_rspStatus <= w_rspStatus;
        if ((w_rspStatus != ST_OK) && (r_errCount != 8'hFF)) begin
          r_errCount <= r_errCount + 8'h01;
        end
      end else if (w_rspDone) begin
        r_rspValid <= 2'b00;
        r_ptr      <= ~r_id;
      end
    end
  end

  assign req_ready    = w_reqReady;
  assign busy         = w_busy;
  assign core_opcode  = w_coreOpcode;
  assign core_data_in = r_coreData;
  assign core_key     = r_coreKey;
  assign rsp_valid    = r_rspValid;
  assign rsp_data     = r_rspData;
  assign rsp_status   = r_rspStatus;
  assign err_count    = r_errCount;

endmodule

// File: tb/tb_spn_req_scheduler.sv
// Directed bench for spn_req_scheduler with a simple registered core stub.
module tb_spn_req_scheduler;
  import spn_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_data;
  logic [63:0] req_key;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [7:0]  err_count;
  logic [1:0]  core_opcode;
  logic [15:0] core_data_in;
  logic [31:0] core_key;
  logic [1:0]  core_valid;
  logic [15:0] core_data_out;

  int checkCount = 0;
  int errorCount = 0;
  int stubMode   = 0;

  always #5 clk = ~clk;

  spn_req_scheduler #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .req_key       (req_key),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .busy          (busy),
    .err_count     (err_count),
    .core_opcode   (core_opcode),
    .core_data_in  (core_data_in),
    .core_key      (core_key),
    .core_valid    (core_valid),
    .core_data_out (core_data_out)
  );

  // Reference cipher used by the core stub and for expected values.
  function automatic logic [15:0] stubEnc(input logic [15:0] d, input logic [31:0] k);
    return (d ^ k[15:0]) + k[31:16];
  endfunction

  function automatic logic [15:0] stubDec(input logic [15:0] c, input logic [31:0] k);
    return (c - k[31:16]) ^ k[15:0];
  endfunction

  // Core stub: answers one cycle after sampling; mode 1 stays silent, mode 2 returns the wrong code.
  always_ff @(posedge clk) begin
    case (stubMode)
      1: core_valid <= OP_NOP;
      2: core_valid <= (core_opcode == OP_NOP) ? OP_NOP :
                       ((core_opcode == OP_ENC) ? OP_DEC : OP_ENC);
      default: core_valid <= core_opcode;
    endcase
    if (core_opcode == OP_ENC) begin
      core_data_out <= stubEnc(core_data_in, core_key);
    end else if (core_opcode == OP_DEC) begin
      core_data_out <= stubDec(core_data_in, core_key);
    end else begin
      core_data_out <= 16'h0000;
    end
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request on requester g.
  task automatic applyStimulus(input int g, input logic [1:0] op, input logic [15:0] data,
                               input logic [31:0] key);
    req_valid[g]          = 1'b1;
    req_op[2*g +: 2]      = op;
    req_data[16*g +: 16]  = data;
    req_key[32*g +: 32]   = key;
  endtask

  // Runs one request up to the point where its response is visible; lat counts edges after the handshake.
  task automatic runRequest(input int g, input logic [1:0] op, input logic [15:0] data,
                            input logic [31:0] key, output logic [15:0] rData,
                            output logic [1:0] rStatus, output int lat);
    int n;
    applyStimulus(g, op, data, key);
    #1;
    n = 0;
    while ((req_ready[g] !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    if (n == 20) checkOutput("grantWait", 64'd0, 64'd1);
    tick();
    req_valid[g] = 1'b0;
    lat = 0;
    while ((rsp_valid[g] !== 1'b1) && (lat < 30)) begin
      tick();
      lat++;
    end
    if (lat == 30) checkOutput("rspWait", 64'd0, 64'd1);
    rData   = rsp_data;
    rStatus = rsp_status;
  endtask

  initial begin
    logic [15:0] cipher;
    logic [15:0] d;
    logic [1:0]  s;
    int          lat;
    logic [15:0] expData;

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = 4'h0;
    req_data  = 32'h0;
    req_key   = 64'h0;
    rsp_ready = 2'b11;
    tick();
    tick();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", req_ready, 0);
    checkOutput("rstRsp", {rsp_valid, rsp_status, rsp_data}, 0);
    checkOutput("rstErr", err_count, 0);
    checkOutput("rstCore", {core_opcode, core_data_in, core_key}, 0);
    rst_n = 1'b1;
    tick();

    // Single encrypt on requester 0 with cycle-accurate latency.
    cipher = stubEnc(16'hABCD, 32'h1234_5678);
    applyStimulus(0, OP_ENC, 16'hABCD, 32'h1234_5678);
    #1;
    checkOutput("t1Ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    checkOutput("t1IssueOp", core_opcode, OP_ENC);
    checkOutput("t1IssueData", core_data_in, 16'hABCD);
    checkOutput("t1IssueKey", core_key, 32'h1234_5678);
    checkOutput("t1Busy", busy, 1);
    tick();
    checkOutput("t1WaitOp", core_opcode, OP_NOP);
    checkOutput("t1WaitRsp", rsp_valid, 2'b00);
    tick();
    checkOutput("t1RspValid", rsp_valid, 2'b01);
    checkOutput("t1Status", rsp_status, ST_OK);
    checkOutput("t1Data", rsp_data, 16'h0FE9);
    checkOutput("t1DataModel", rsp_data, cipher);
    tick();
    checkOutput("t1Idle", {busy, rsp_valid}, 0);
    checkOutput("t1Hold", core_data_in, 16'hABCD);

    // Round trip: requester 1 decrypts the ciphertext.
    runRequest(1, OP_DEC, cipher, 32'h1234_5678, d, s, lat);
    tick();
    checkOutput("t2Data", d, 16'hABCD);
    checkOutput("t2Status", s, ST_OK);
    checkOutput("t2Lat", lat, 2);

    // Fairness with both requesters continuously valid.
    applyStimulus(0, OP_ENC, 16'h1111, 32'hAAAA_0000);
    applyStimulus(1, OP_ENC, 16'h2222, 32'h5555_FFFF);
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("fairGrant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tick();
      tick();
      checkOutput("fairRsp", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      expData = (k % 2 == 0) ? stubEnc(16'h1111, 32'hAAAA_0000) : stubEnc(16'h2222, 32'h5555_FFFF);
      checkOutput("fairData", rsp_data, expData);
      tick();
    end
    req_valid = 2'b00;

    // Illegal opcode on requester 1 bypasses the core.
    applyStimulus(1, 2'b11, 16'hBEEF, 32'hCAFE_BABE);
    #1;
    checkOutput("t4Ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    checkOutput("t4CoreOp", core_opcode, OP_NOP);
    checkOutput("t4RspValid", rsp_valid, 2'b10);
    checkOutput("t4Status", rsp_status, ST_ILLEGAL);
    checkOutput("t4Data", rsp_data, 0);
    checkOutput("t4Err", err_count, 1);
    checkOutput("t4CoreHold", core_data_in, 16'h2222);
    tick();

    // Silent core produces TIMEOUT after four WAIT cycles.
    stubMode = 1;
    runRequest(0, OP_ENC, 16'h1234, 32'h0F0F_0F0F, d, s, lat);
    tick();
    checkOutput("t5Status", s, ST_TIMEOUT);
    checkOutput("t5Data", d, 0);
    checkOutput("t5Lat", lat, 5);
    checkOutput("t5Err", err_count, 2);

    // Wrong valid code produces MISMATCH.
    stubMode = 2;
    runRequest(0, OP_ENC, 16'h4321, 32'h0F0F_0F0F, d, s, lat);
    tick();
    checkOutput("t6Status", s, ST_MISMATCH);
    checkOutput("t6Data", d, 0);
    checkOutput("t6Lat", lat, 2);
    checkOutput("t6Err", err_count, 3);
    stubMode = 0;

    // Backpressure: response is held and no new request is taken.
    rsp_ready = 2'b00;
    expData = stubDec(16'h7777, 32'h0102_0304);
    runRequest(1, OP_DEC, 16'h7777, 32'h0102_0304, d, s, lat);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bpHold", {rsp_valid, rsp_status, rsp_data, req_ready, busy},
                  {2'b10, ST_OK, expData, 2'b00, 1'b1});
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    tick();
    checkOutput("bpRelease", {rsp_valid, busy}, 0);
    rsp_ready = 2'b11;

    // Move the pointer to 1, then reset in the middle of a WAIT.
    runRequest(0, OP_ENC, 16'h0001, 32'h0000_0001, d, s, lat);
    tick();
    applyStimulus(1, OP_ENC, 16'h5A5A, 32'h1111_2222);
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    checkOutput("t7InWait", busy, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("t7RstOuts", {busy, rsp_valid, rsp_data, rsp_status, err_count, core_opcode,
                              core_data_in, req_ready}, 0);
    checkOutput("t7RstKey", core_key, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("t7Dropped", rsp_valid, 0);
    req_valid = 2'b11;
    #1;
    checkOutput("t7Ptr", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    checkOutput("t7Rsp", rsp_valid, 2'b01);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
